qs_range_scheduler: RTL and testbench

//  Sub-range scheduler for the quick-sort engine. Holds a LIFO of pending (lo,hi) index ranges.

---
 rtl/qs_pkg.sv | 30 +++
 rtl/qs_range_stack.sv | 67 ++++++
 rtl/qs_range_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_qs_range_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qs_pkg.sv
// Shared types and sizing helpers for the quick-sort range scheduler.
// State encoding plus index/depth/record-width functions derived from K.
package qs_pkg;

    localparam int QS_K_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_POP   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_PUSH  = 3'd5,
        ST_DONE  = 3'd6
    } qs_state_t;

    function automatic int qs_iw(input int k);
        return (k < 2) ? 1 : $clog2(k);
    endfunction

    function automatic int qs_depth(input int k);
        return $clog2(k) + 1;
    endfunction

    // A range record is {lo, hi}, each one index wide.
    function automatic int qs_rw(input int iw);
        return 2 * iw;
    endfunction

endpackage

// File: rtl/qs_range_stack.sv
// Register LIFO of packed (lo,hi) records, top kept at entry 0.
// Accepts 0-2 pushes or one pop per cycle; pushes that do not fit are dropped.
module qs_range_stack
    import qs_pkg::*;
#(
    parameter int RW = 8,
    parameter int D  = 5,
    localparam int SPW = $clog2(D + 1)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [1:0]     i_push_n,
    input  logic [RW-1:0]  i_push_a,
    input  logic [RW-1:0]  i_push_b,
    input  logic           i_pop,
    output logic [RW-1:0]  o_top,
    output logic [SPW-1:0] o_sp,
    output logic           o_full,
    output logic           o_empty,
    output logic           o_overflow
);

    logic [RW-1:0]  r_mem [D];
    logic [SPW-1:0] r_sp;
    logic [SPW:0]   w_room;
    logic [1:0]     w_n_eff;

    // Only as many entries as fit are stored; push_a (pushed first) wins a single slot.
    assign w_room   = (SPW + 1)'(D) - {1'b0, r_sp};
    assign w_n_eff  = ((SPW + 1)'(i_push_n) > w_room) ? w_room[1:0] : i_push_n;
    assign o_overflow = (w_n_eff != i_push_n);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sp <= '0;
        end else if (w_n_eff != 2'd0) begin
            r_sp <= r_sp + SPW'(w_n_eff);
        end else if (i_pop && (r_sp != '0)) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        case (w_n_eff)
            2'd1: begin
                r_mem[0] <= i_push_a;
                for (int i = 1; i < D; i++) r_mem[i] <= r_mem[i-1];
            end
            2'd2: begin
                r_mem[0] <= i_push_b;
                for (int i = 1; i < 2 && i < D; i++) r_mem[i] <= i_push_a;
                for (int i = 2; i < D; i++) r_mem[i] <= r_mem[i-2];
            end
            default: begin
                if (i_pop) begin
                    for (int i = 0; i < D - 1; i++) r_mem[i] <= r_mem[i+1];
                end
            end
        endcase
    end

    assign o_top   = r_mem[0];
    assign o_sp    = r_sp;
    assign o_full  = (r_sp == SPW'(D));
    assign o_empty = (r_sp == '0);

endmodule

// File: rtl/qs_range_scheduler.sv
// Quick-sort sub-range scheduler: pops ranges, drives the partition unit, pushes survivors.
// Optional QS_STATS_EN adds a saturating part_count output of issued partitions.
module qs_range_scheduler
    import qs_pkg::*;
#(
    parameter int K  = QS_K_DEFAULT,
    parameter int IW = qs_iw(K),
    parameter int D  = qs_depth(K)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          part_start,
    output logic [IW-1:0] part_lo,
    output logic [IW-1:0] part_hi,
    input  logic          part_done,
    input  logic [IW-1:0] part_pivot,
    output logic          busy,
    output logic          finish,
    output logic          err
`ifdef QS_STATS_EN
    ,
    output logic [IW:0]   part_count
`endif
);

    localparam int RW  = qs_rw(IW);
    localparam int SPW = $clog2(D + 1);
    localparam logic [IW:0] C_TWO = (IW + 1)'(2);

    typedef struct packed {
        logic [IW-1:0] lo;
        logic [IW-1:0] hi;
    } range_t;

    qs_state_t     r_state;
    logic [IW-1:0] r_lo, r_hi, r_p;
    logic          r_part_start, r_busy, r_finish, r_err;

    logic [1:0]    w_push_n;
    range_t        w_push_a, w_push_b, w_top, w_left, w_right;
    logic          w_pop;
    logic [SPW-1:0] w_sp;
    logic          w_full, w_empty, w_overflow;
    logic          w_unused_stack;

    logic [IW:0]   w_lo_x, w_hi_x, w_p_x, w_left_sz, w_right_sz;
    logic          w_bad_pivot, w_left_ok, w_right_ok;

    // Widen by one bit so p-1 / p+1 comparisons never wrap.
    assign w_lo_x      = {1'b0, r_lo};
    assign w_hi_x      = {1'b0, r_hi};
    assign w_p_x       = {1'b0, r_p};
    assign w_bad_pivot = (w_p_x < w_lo_x) || (w_p_x > w_hi_x);
    assign w_left_ok   = !w_bad_pivot && (w_p_x >= w_lo_x + C_TWO);
    assign w_right_ok  = !w_bad_pivot && (w_hi_x >= w_p_x + C_TWO);
    assign w_left_sz   = w_p_x - w_lo_x;
    assign w_right_sz  = w_hi_x - w_p_x;
    assign w_left      = '{lo: r_lo, hi: r_p - IW'(1)};
    assign w_right     = '{lo: r_p + IW'(1), hi: r_hi};

    always_comb begin
        w_push_n = 2'd0;
        w_push_a = '0;
        w_push_b = '0;
        case (r_state)
            ST_LOAD: begin
                if (K >= 2) begin
                    w_push_n = 2'd1;
                    w_push_a = '{lo: '0, hi: IW'(K - 1)};
                end
            end
            ST_PUSH: begin
                if (w_left_ok && w_right_ok) begin
                    // Larger first so the smaller range sits on top and runs next.
                    w_push_n = 2'd2;
                    if (w_left_sz > w_right_sz) begin
                        w_push_a = w_left;
                        w_push_b = w_right;
                    end else begin
                        w_push_a = w_right;
                        w_push_b = w_left;
                    end
                end else if (w_left_ok) begin
                    w_push_n = 2'd1;
                    w_push_a = w_left;
                end else if (w_right_ok) begin
                    w_push_n = 2'd1;
                    w_push_a = w_right;
                end
            end
            default: ;
        endcase
    end

    assign w_pop = (r_state == ST_POP) && !w_empty;

    qs_range_stack #(
        .RW (RW),
        .D  (D)
    ) u_stack (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push_n   (w_push_n),
        .i_push_a   (w_push_a),
        .i_push_b   (w_push_b),
        .i_pop      (w_pop),
        .o_top      (w_top),
        .o_sp       (w_sp),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (w_overflow)
    );

    assign w_unused_stack = ^{w_full, w_sp};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_lo         <= '0;
            r_hi         <= '0;
            r_p          <= '0;
            r_part_start <= 1'b0;
            r_busy       <= 1'b0;
            r_finish     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_part_start <= 1'b0;
            r_finish     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_POP;
                    r_err   <= 1'b0;
                end
                ST_POP: begin
                    if (w_empty) begin
                        r_state  <= ST_DONE;
                        r_finish <= 1'b1;
                    end else begin
                        r_lo         <= w_top.lo;
                        r_hi         <= w_top.hi;
                        r_state      <= ST_ISSUE;
                        r_part_start <= 1'b1;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (part_done) begin
                        r_p     <= part_pivot;
                        r_state <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    r_state <= ST_POP;
                    if (w_bad_pivot || w_overflow) r_err <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef QS_STATS_EN
    logic [IW:0] r_part_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_part_count <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_part_count <= '0;
        end else if (w_pop && (r_part_count != '1)) begin
            r_part_count <= r_part_count + (IW + 1)'(1);
        end
    end

    assign part_count = r_part_count;
`endif

    assign part_start = r_part_start;
    assign part_lo    = r_lo;
    assign part_hi    = r_hi;
    assign busy       = r_busy;
    assign finish     = r_finish;
    assign err        = r_err;

endmodule

// File: tb/tb_qs_range_scheduler.sv
// Scoreboard bench for qs_range_scheduler (K=10 main instance, K=1 side instance).
// A queue-based range model predicts every issued job and the final finish/err.
module tb_qs_range_scheduler;

    localparam int K  = 10;
    localparam int IW = 4;
    localparam int KD = $clog2(K) + 1;

    logic          clk;
    logic          reset_n;
    logic          start, part_start, part_done, busy, finish, err;
    logic [IW-1:0] part_lo, part_hi, part_pivot;
    logic          start1, part_start1, part_done1, busy1, finish1, err1;
    logic [0:0]    part_lo1, part_hi1, part_pivot1;
`ifdef QS_STATS_EN
    logic [IW:0]   part_count;
    logic [1:0]    part_count1;
`endif

    qs_range_scheduler #(.K(K)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .part_start (part_start),
        .part_lo    (part_lo),
        .part_hi    (part_hi),
        .part_done  (part_done),
        .part_pivot (part_pivot),
        .busy       (busy),
        .finish     (finish),
        .err        (err)
`ifdef QS_STATS_EN
        ,
        .part_count (part_count)
`endif
    );

    qs_range_scheduler #(.K(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start1),
        .part_start (part_start1),
        .part_lo    (part_lo1),
        .part_hi    (part_hi1),
        .part_done  (part_done1),
        .part_pivot (part_pivot1),
        .busy       (busy1),
        .finish     (finish1),
        .err        (err1)
`ifdef QS_STATS_EN
        ,
        .part_count (part_count1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    typedef struct { bit fin; int lo; int hi; bit e; } ev_t;
    typedef struct { int lo; int hi; } rng_t;

    ev_t  expq[$];
    rng_t m_stk[$];
    int   m_lo, m_hi, m_jobs;
    bit   m_err, m_done;
    ev_t  mon_e;

    function automatic void model_push(input int lo, input int hi);
        rng_t r;
        r.lo = lo;
        r.hi = hi;
        if (m_stk.size() >= KD) m_err = 1'b1;
        else m_stk.push_back(r);
    endfunction

    function automatic void model_next();
        ev_t  e;
        rng_t r;
        if (m_stk.size() == 0) begin
            m_done = 1'b1;
            e = '{fin: 1'b1, lo: 0, hi: 0, e: m_err};
        end else begin
            r = m_stk.pop_back();
            m_lo = r.lo;
            m_hi = r.hi;
            m_jobs++;
            e = '{fin: 1'b0, lo: r.lo, hi: r.hi, e: 1'b0};
        end
        expq.push_back(e);
    endfunction

    function automatic void model_start();
        m_stk.delete();
        m_err  = 1'b0;
        m_done = 1'b0;
        m_jobs = 0;
        model_push(0, K - 1);
        model_next();
    endfunction

    // Survivors: segments of two or more elements, the larger stacked underneath.
    function automatic void model_done(input int p);
        int  nl, nr;
        if (p < m_lo || p > m_hi) begin
            m_err = 1'b1;
        end else begin
            nl = p - m_lo;
            nr = m_hi - p;
            if (nl >= 2 && nr >= 2) begin
                if (nl > nr) begin
                    model_push(m_lo, p - 1);
                    model_push(p + 1, m_hi);
                end else begin
                    model_push(p + 1, m_hi);
                    model_push(m_lo, p - 1);
                end
            end else if (nl >= 2) begin
                model_push(m_lo, p - 1);
            end else if (nr >= 2) begin
                model_push(p + 1, m_hi);
            end
        end
        model_next();
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (part_start && finish) check("start_finish_overlap", 1, 0);
            if (part_start) begin
                if (expq.size() == 0) begin
                    check("unexpected_part_start", 1, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check("job_kind", 0, int'(mon_e.fin));
                    if (!mon_e.fin) begin
                        check("job_lo", int'(part_lo), mon_e.lo);
                        check("job_hi", int'(part_hi), mon_e.hi);
                        check("job_busy", int'(busy), 1);
                    end
                end
            end
            if (finish) begin
                if (expq.size() == 0) begin
                    check("unexpected_finish", 1, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check("finish_kind", int'(mon_e.fin), 1);
                    check("finish_err", int'(err), int'(mon_e.e));
                end
            end
        end
    end

    task automatic run_sort(input int first_piv, input int mode, input bit chk_lat, input bit poke);
        int n;
        int piv;
        bit first_job;
        first_job = 1'b1;
        start = 1'b1;
        model_start();
        @(negedge clk);
        start = 1'b0;
        check("err_cleared_by_start", int'(err), 0);
        if (chk_lat) begin
            check("lat_cycle1", int'(part_start), 0);
            @(negedge clk);
            check("lat_cycle2", int'(part_start), 0);
            check("busy_running", int'(busy), 1);
            @(negedge clk);
            check("lat_cycle3", int'(part_start), 1);
        end
        while (!m_done) begin
            n = 0;
            while (!part_start && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!part_start) begin
                check("part_start_timeout", 0, 1);
                return;
            end
            if (poke) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                poke = 1'b0;
            end
            repeat (1 + $urandom_range(3, 0)) @(negedge clk);
            if (first_job && first_piv >= 0) piv = first_piv;
            else if (mode == 0) piv = m_hi;
            else piv = int'($urandom_range(m_hi, m_lo));
            first_job = 1'b0;
            check("lo_stable", int'(part_lo), m_lo);
            check("hi_stable", int'(part_hi), m_hi);
            part_pivot = IW'(piv);
            part_done  = 1'b1;
            @(negedge clk);
            part_done  = 1'b0;
            model_done(piv);
        end
        n = 0;
        while (!finish && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!finish) check("finish_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        start = 1'b0; part_done = 1'b0; part_pivot = '0;
        start1 = 1'b0; part_done1 = 1'b0; part_pivot1 = '0;
        repeat (2) @(negedge clk);
        check("rst_part_start", int'(part_start), 0);
        check("rst_part_lo", int'(part_lo), 0);
        check("rst_part_hi", int'(part_hi), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_finish", int'(finish), 0);
        check("rst_err", int'(err), 0);
        check("rst_k1_busy", int'(busy1), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Latency and first job, then descending pivot=hi chain of 9 jobs.
        run_sort(-1, 0, 1'b1, 1'b0);
        check("chain_jobs", m_jobs, 9);
        check("chain_err", int'(err), 0);
`ifdef QS_STATS_EN
        check("part_count_chain", int'(part_count), 9);
`endif
        check("idle_busy", int'(busy), 0);

        run_sort(4, 1, 1'b0, 1'b0);
        run_sort(0, 1, 1'b0, 1'b0);
        run_sort(9, 1, 1'b0, 1'b0);

        run_sort(12, 1, 1'b0, 1'b0);
        check("bad_pivot_err_sticky", int'(err), 1);
        check("bad_pivot_jobs", m_jobs, 1);
        run_sort(-1, 1, 1'b0, 1'b0);

        run_sort(-1, 1, 1'b0, 1'b1);
        for (int t = 0; t < 12; t++) run_sort(-1, 1, 1'b0, 1'b0);

        // Reset while waiting for the partition unit.
        start = 1'b1;
        model_start();
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!part_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_reach", int'(part_start), 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        expq.delete();
        reset_n = 1'b1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_part_start", int'(part_start), 0);
        check("midrst_sp", int'(dut.u_stack.o_sp), 0);
        part_pivot = 4'd3;
        part_done  = 1'b1;
        @(negedge clk);
        part_done  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("late_done_busy", int'(busy), 0);
            check("late_done_part_start", int'(part_start), 0);
        end

        // K=1 instance: nothing to partition, finish after LOAD and POP.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("k1_c1_finish", int'(finish1), 0);
        @(negedge clk);
        check("k1_c2_finish", int'(finish1), 0);
        check("k1_c2_busy", int'(busy1), 1);
        @(negedge clk);
        check("k1_c3_finish", int'(finish1), 1);
        check("k1_c3_part_start", int'(part_start1), 0);
        check("k1_err", int'(err1), 0);
        @(negedge clk);
        check("k1_done_busy", int'(busy1), 0);
        check("k1_after_finish", int'(finish1), 0);

        check("scoreboard_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
